// File: rtl/adex_step_scheduler.sv
// ---------------------------------------------------------------------------
// adex_step_scheduler
//   Sequences one shared AdEx update datapath across N_NEURONS neurons. Each
//   accepted tick starts a sweep over neurons 0..N_NEURONS-1. For every neuron
//   the block does one of two things:
//     - if the neuron is refractory, it holds vmem at V_RESET and counts the
//       refractory period down by one;
//     - otherwise it issues (vmem, w, i_in) to the datapath and waits for the
//       result. It then applies the threshold, the reset and the adaptation
//       jump, and emits a spike event when the neuron fires.
//   Neuron state (vmem, w, refractory count) is held here.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   tick            timestep strobe; i_in_flat is sampled when it is accepted
//   i_in_flat       16-bit signed current per neuron, neuron k at [16k+15:16k]
//   dp_valid/ready  operand handshake; dp_idx/dp_vmem/dp_w/dp_iin are operands
//   dp_done         one-cycle result strobe with dp_vmem_nxt / dp_w_nxt
//   spike_valid     one-cycle pulse per spike; spike_idx is the neuron index
//   busy            sweep in progress
//   step_done       one-cycle pulse at the end of a sweep
//   overrun         sticky flag: a tick arrived while a sweep was running
//   rd_idx          debug select; rd_vmem / rd_w are combinational reads
// ---------------------------------------------------------------------------
module adex_step_scheduler #(
  parameter int                 N_NEURONS    = 4,
  parameter int                 IDX_W        = 2,
  parameter logic signed [15:0] V_THRESH     = 16'sd1000,
  parameter logic signed [15:0] V_RESET      = 16'sd0,
  parameter logic signed [15:0] B_JUMP       = 16'sd64,
  parameter int                 REFRAC_TICKS = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick,
  input  logic [16*N_NEURONS-1:0] i_in_flat,
  output logic                    dp_valid,
  input  logic                    dp_ready,
  output logic [IDX_W-1:0]        dp_idx,
  output logic [15:0]             dp_vmem,
  output logic [15:0]             dp_w,
  output logic [15:0]             dp_iin,
  input  logic                    dp_done,
  input  logic [15:0]             dp_vmem_nxt,
  input  logic [15:0]             dp_w_nxt,
  output logic                    spike_valid,
  output logic [IDX_W-1:0]        spike_idx,
  output logic                    busy,
  output logic                    step_done,
  output logic                    overrun,
  input  logic [IDX_W-1:0]        rd_idx,
  output logic [15:0]             rd_vmem,
  output logic [15:0]             rd_w
);

  localparam int REF_W = (REFRAC_TICKS < 1) ? 1 : $clog2(REFRAC_TICKS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);
  localparam logic [REF_W-1:0] REF_LOAD = REF_W'(REFRAC_TICKS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic        [IDX_W-1:0] idx;
  logic signed [15:0]      vmem    [N_NEURONS];
  logic signed [15:0]      w       [N_NEURONS];
  logic        [REF_W-1:0] refrac  [N_NEURONS];
  logic signed [15:0]      iin_lat [N_NEURONS];
  logic signed [15:0]      vmem_cap;
  logic signed [15:0]      w_cap;

  logic               refractory;
  logic               last;
  logic               spike;
  logic signed [16:0] w_sum;
  logic signed [15:0] w_jump;

  assign refractory = (refrac[idx] != '0);
  assign last       = (idx == LAST_IDX);
  assign spike      = (vmem_cap > V_THRESH);

  // The sum is one bit wider than w. When its top two bits differ, the add
  // has left the 16-bit range, and the top bit gives the direction of the clamp.
  assign w_sum = {w_cap[15], w_cap} + {B_JUMP[15], B_JUMP};

  always_comb begin
    if (w_sum[16] != w_sum[15]) begin
      w_jump = w_sum[16] ? 16'sh8000 : 16'sh7fff;
    end else begin
      w_jump = w_sum[15:0];
    end
  end

  // The outputs are decoded from the state. They are therefore 0 in reset and
  // clear at once on an asynchronous abort.
  assign dp_valid    = (state == S_ISSUE) && !refractory;
  assign dp_idx      = idx;
  assign dp_vmem     = vmem[idx];
  assign dp_w        = w[idx];
  assign dp_iin      = iin_lat[idx];
  assign spike_valid = (state == S_WRITE) && spike;
  assign spike_idx   = idx;
  assign busy        = (state == S_ISSUE) || (state == S_WAIT) || (state == S_WRITE);
  assign step_done   = (state == S_DONE);
  assign rd_vmem     = vmem[rd_idx];
  assign rd_w        = w[rd_idx];

  // NOTE: sequential state uses non-blocking assignments. Every flop then
  // samples the values from before the edge, so the order of the blocks does
  // not matter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: state_nxt is given a default before the case statement. Every path
  // then assigns it, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (tick) state_nxt = S_ISSUE;
      S_ISSUE: begin
        if (refractory) begin
          state_nxt = last ? S_DONE : S_ISSUE;
        end else if (dp_ready) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT:  if (dp_done) state_nxt = S_WRITE;
      S_WRITE: state_nxt = last ? S_DONE : S_ISSUE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: the neuron state arrays are cleared by reset, because an abort must
  // leave every neuron at rest. This keeps them in flops rather than RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx      <= '0;
      vmem_cap <= '0;
      w_cap    <= '0;
      overrun  <= 1'b0;
      for (int k = 0; k < N_NEURONS; k++) begin
        vmem[k]    <= '0;
        w[k]       <= '0;
        refrac[k]  <= '0;
        iin_lat[k] <= '0;
      end
    end else begin
      if (tick && (state != S_IDLE)) begin
        overrun <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (tick) begin
            idx <= '0;
            for (int k = 0; k < N_NEURONS; k++) begin
              iin_lat[k] <= i_in_flat[16*k +: 16];
            end
          end
        end
        S_ISSUE: begin
          // A refractory neuron skips the datapath and takes one cycle.
          if (refractory) begin
            vmem[idx]   <= V_RESET;
            refrac[idx] <= refrac[idx] - REF_W'(1);
            if (!last) idx <= idx + IDX_W'(1);
          end
        end
        S_WAIT: begin
          if (dp_done) begin
            vmem_cap <= dp_vmem_nxt;
            w_cap    <= dp_w_nxt;
          end
        end
        S_WRITE: begin
          if (spike) begin
            vmem[idx]   <= V_RESET;
            w[idx]      <= w_jump;
            refrac[idx] <= REF_LOAD;
          end else begin
            vmem[idx] <= vmem_cap;
            w[idx]    <= w_cap;
          end
          if (!last) idx <= idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adex_step_scheduler.sv
// ---------------------------------------------------------------------------
// tb_adex_step_scheduler
//   Scoreboard bench. Before each tick, a behavioural model of one sweep
//   computes the expected handshakes, spikes and final neuron state, and
//   queues them. A stub datapath answers the handshakes. A separate monitor
//   pops the queues and compares whenever the DUT presents a handshake, a
//   spike or a step_done.
// ---------------------------------------------------------------------------
module tb_adex_step_scheduler;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int VTH = 1000;
  localparam int BJ  = 64;
  localparam int RT  = 3;

  typedef int iin_t [N];
  typedef struct {
    int idx;
    int vmem;
    int w;
    int iin;
  } hs_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          tick;
  logic [16*N-1:0] i_in_flat;
  logic          dp_valid, dp_ready, dp_done;
  logic [IW-1:0] dp_idx, spike_idx, rd_idx;
  logic [15:0]   dp_vmem, dp_w, dp_iin, dp_vmem_nxt, dp_w_nxt, rd_vmem, rd_w;
  logic          spike_valid, busy, step_done, overrun;

  adex_step_scheduler dut (
    .clk(clk), .rst(rst), .tick(tick), .i_in_flat(i_in_flat),
    .dp_valid(dp_valid), .dp_ready(dp_ready), .dp_idx(dp_idx),
    .dp_vmem(dp_vmem), .dp_w(dp_w), .dp_iin(dp_iin),
    .dp_done(dp_done), .dp_vmem_nxt(dp_vmem_nxt), .dp_w_nxt(dp_w_nxt),
    .spike_valid(spike_valid), .spike_idx(spike_idx), .busy(busy),
    .step_done(step_done), .overrun(overrun),
    .rd_idx(rd_idx), .rd_vmem(rd_vmem), .rd_w(rd_w)
  );

  always #5 clk = ~clk;

  hs_t exp_hs [$];
  int  exp_spk [$];
  int  exp_done;
  int  m_vmem [N];
  int  m_w    [N];
  int  m_ref  [N];
  int  n_checks = 0;
  int  n_pass   = 0;
  int  w_mode   = 0;
  int  stall_left = 0;
  bit  wait_flag  = 1'b0;
  hs_t mon_e;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int s16(input logic [15:0] x);
    return int'($signed(x));
  endfunction

  function automatic int clamp16(input int x);
    if (x > 32767)  return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  // Stub datapath behaviour, shared by the stub and the model.
  function automatic int stub_v(input int v, input int iin);
    return v + iin;
  endfunction

  function automatic int stub_w(input int v, input int w, input int iin);
    if (w_mode == 1 && (v + iin) > VTH) return 32740;
    if (w_mode == 2) return clamp16(w + iin / 8);
    return w;
  endfunction

  // Behavioural model of one sweep.
  task automatic model_sweep(input iin_t iin);
    int nv, nw;
    for (int k = 0; k < N; k++) begin
      if (m_ref[k] > 0) begin
        m_vmem[k] = 0;
        m_ref[k]--;
      end else begin
        exp_hs.push_back('{k, m_vmem[k], m_w[k], iin[k]});
        nv = stub_v(m_vmem[k], iin[k]);
        nw = stub_w(m_vmem[k], m_w[k], iin[k]);
        if (nv > VTH) begin
          exp_spk.push_back(k);
          m_vmem[k] = 0;
          m_w[k]    = clamp16(nw + BJ);
          m_ref[k]  = RT;
        end else begin
          m_vmem[k] = nv;
          m_w[k]    = nw;
        end
      end
    end
    exp_done++;
  endtask

  task automatic check_state(input string tag);
    for (int k = 0; k < N; k++) begin
      rd_idx = IW'(k);
      #1;
      check($sformatf("%s_vmem%0d", tag, k), s16(rd_vmem), m_vmem[k]);
      check($sformatf("%s_w%0d", tag, k), s16(rd_w), m_w[k]);
    end
  endtask

  task automatic run_sweep(input iin_t iin, input bit do_overrun, input int stall);
    int t;
    model_sweep(iin);
    stall_left = stall;
    @(negedge clk);
    for (int k = 0; k < N; k++) i_in_flat[16*k +: 16] = 16'(iin[k]);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    i_in_flat = {$urandom, $urandom};  // must not be relatched
    check("busy_after_tick", int'(busy), 1);
    if (do_overrun) begin
      repeat (2) @(negedge clk);
      i_in_flat = {$urandom, $urandom};
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      check("overrun_set", int'(overrun), 1);
    end
    t = 0;
    while (exp_done != 0 && t < 2000) begin
      @(negedge clk);
      #2;
      t++;
    end
    if (exp_done != 0) begin
      check("sweep_timeout", exp_done, 0);
      exp_done = 0;
    end
    check("busy_after_sweep", int'(busy), 0);
    check_state("sweep");
  endtask

  // Stub datapath: optional ready stall; done two cycles after acceptance.
  initial begin : stub
    logic [63:0] held;
    bit stalling;
    int v, wv, iv;
    stalling = 1'b0;
    held = '0;
    dp_ready = 1'b1;
    dp_done = 1'b0;
    dp_vmem_nxt = '0;
    dp_w_nxt = '0;
    forever begin
      @(negedge clk);
      if (dp_valid && stall_left > 0) begin
        if (!stalling) begin
          held = {14'd0, dp_idx, dp_vmem, dp_w, dp_iin};
          stalling = 1'b1;
        end else begin
          check("stall_hold", int'({14'd0, dp_idx, dp_vmem, dp_w, dp_iin} == held), 1);
        end
        dp_ready = 1'b0;
        stall_left--;
      end else begin
        dp_ready = 1'b1;
      end
      if (dp_valid && dp_ready) begin
        if (stalling) begin
          check("stall_release", int'({14'd0, dp_idx, dp_vmem, dp_w, dp_iin} == held), 1);
          stalling = 1'b0;
        end
        v  = s16(dp_vmem);
        wv = s16(dp_w);
        iv = s16(dp_iin);
        @(negedge clk);
        wait_flag = 1'b1;
        @(negedge clk);
        dp_vmem_nxt = 16'(stub_v(v, iv));
        dp_w_nxt    = 16'(stub_w(v, wv, iv));
        dp_done     = 1'b1;
        @(negedge clk);
        dp_done   = 1'b0;
        wait_flag = 1'b0;
      end
    end
  end

  // Monitor: compares DUT events against the queued expectations.
  initial begin : monitor
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        if (dp_valid && dp_ready) begin
          if (exp_hs.size() == 0) begin
            check("unexpected_issue", int'(dp_idx), -1);
          end else begin
            mon_e = exp_hs.pop_front();
            check("hs_idx", int'(dp_idx), mon_e.idx);
            check("hs_vmem", s16(dp_vmem), mon_e.vmem);
            check("hs_w", s16(dp_w), mon_e.w);
            check("hs_iin", s16(dp_iin), mon_e.iin);
          end
        end
        if (spike_valid) begin
          if (exp_spk.size() == 0) check("unexpected_spike", int'(spike_idx), -1);
          else check("spike_idx", int'(spike_idx), exp_spk.pop_front());
        end
        if (step_done) begin
          if (exp_done == 0) begin
            check("unexpected_step_done", 1, 0);
          end else begin
            exp_done--;
            check("hs_drained", exp_hs.size(), 0);
            check("spk_drained", exp_spk.size(), 0);
            exp_hs.delete();
            exp_spk.delete();
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    iin_t iin;
    int t;
    rst = 1'b1;
    tick = 1'b0;
    i_in_flat = '0;
    rd_idx = '0;
    exp_done = 0;
    for (int k = 0; k < N; k++) begin
      m_vmem[k] = 0;
      m_w[k] = 0;
      m_ref[k] = 0;
    end
    repeat (2) @(negedge clk);
    #1;
    check("rst_dp_valid", int'(dp_valid), 0);
    check("rst_spike_valid", int'(spike_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_step_done", int'(step_done), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_dp_idx", int'(dp_idx), 0);
    @(negedge clk);
    rst = 1'b0;
    check_state("rst");

    // Uniform current: every vmem becomes 10, with four ordered handshakes.
    iin = '{10, 10, 10, 10};
    run_sweep(iin, 1'b0, 0);
    check("vmem_after_first", s16(rd_vmem), 10);

    // Bring neuron 2 up to 995, then let it cross the threshold.
    iin = '{0, 0, 985, 0};
    run_sweep(iin, 1'b0, 0);
    iin = '{10, 10, 10, 10};
    run_sweep(iin, 1'b0, 0);
    rd_idx = 2'd2;
    #1;
    check("spike_vmem2", s16(rd_vmem), 0);
    check("spike_w2", s16(rd_w), 64);

    // Three refractory sweeps skip neuron 2; the fourth issues it again.
    for (int s = 0; s < 4; s++) run_sweep(iin, 1'b0, 0);

    // The adaptation jump saturates at +32767.
    w_mode = 1;
    iin = '{2000, 0, 0, 0};
    run_sweep(iin, 1'b0, 0);
    rd_idx = 2'd0;
    #1;
    check("sat_w0", s16(rd_w), 32767);
    w_mode = 0;

    // A ready stall of five cycles holds the operands.
    iin = '{10, 20, 30, 40};
    run_sweep(iin, 1'b0, 5);

    // A tick during a sweep sets the sticky overrun flag only.
    check("overrun_before", int'(overrun), 0);
    iin = '{5, 5, 5, 5};
    run_sweep(iin, 1'b1, 0);
    run_sweep(iin, 1'b0, 0);
    check("overrun_sticky", int'(overrun), 1);

    // Randomised sweeps with random stalls.
    w_mode = 2;
    for (int s = 0; s < 12; s++) begin
      for (int k = 0; k < N; k++) iin[k] = int'($urandom_range(800, 0)) - 200;
      run_sweep(iin, 1'b0, int'($urandom_range(3, 0)));
    end

    // Clear all refractory periods before the abort test.
    w_mode = 0;
    iin = '{0, 0, 0, 0};
    for (int s = 0; s < 3; s++) run_sweep(iin, 1'b0, 0);

    // Reset in WAIT aborts the sweep; the late dp_done must do nothing.
    iin = '{7, 7, 7, 7};
    model_sweep(iin);
    @(negedge clk);
    for (int k = 0; k < N; k++) i_in_flat[16*k +: 16] = 16'(iin[k]);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    t = 0;
    while (!wait_flag && t < 100) begin
      @(negedge clk);
      #2;
      t++;
    end
    check("reached_wait", int'(wait_flag), 1);
    rst = 1'b1;
    #1;
    check("abort_dp_valid", int'(dp_valid), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_overrun", int'(overrun), 0);
    #1;
    rst = 1'b0;
    exp_hs.delete();
    exp_spk.delete();
    exp_done = 0;
    for (int k = 0; k < N; k++) begin
      m_vmem[k] = 0;
      m_w[k] = 0;
      m_ref[k] = 0;
    end
    repeat (5) @(negedge clk);
    #1;
    check("post_abort_dp_valid", int'(dp_valid), 0);
    check("post_abort_busy", int'(busy), 0);
    check("post_abort_step_done", int'(step_done), 0);
    check("post_abort_spike", int'(spike_valid), 0);
    check("post_abort_dp_idx", int'(dp_idx), 0);
    check_state("abort");

    // A normal sweep after the abort starts from cleared state.
    iin = '{3, 4, 5, 6};
    run_sweep(iin, 1'b0, 0);

    repeat (3) @(negedge clk);
    check("final_exp_done", exp_done, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
